// File: rtl/tl_pkg.sv
// tl_pkg: lamp codes, FSM state encoding and width helpers shared by the
// N-way traffic-light controller and its round-robin picker.
package tl_pkg;

    // Two-bit lamp code driven per road
    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_LEFT   = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    // Phase of the currently served road
    typedef enum logic [1:0] {
        S_G  = 2'b00,   // through green
        S_GY = 2'b01,   // yellow closing the through green
        S_L  = 2'b10,   // protected left arrow
        S_LY = 2'b11    // yellow closing the left arrow
    } state_t;

    // Width of a road index: never narrower than one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of an up-counter that must hold values 0..max_val
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tl_rr_next.sv
// tl_rr_next: combinational round-robin picker. Returns the first road after
// r (wrapping) that has demand; falls back to the plain successor of r so
// that every road keeps being visited even with no traffic anywhere.
module tl_rr_next
    import tl_pkg::*;
#(
    parameter int N_ROAD = 2,
    parameter int IDXW   = 1
) (
    input  logic [IDXW-1:0]   r,
    input  logic [N_ROAD-1:0] demand,
    output logic [IDXW-1:0]   next
);

    // Pick the demanding road with the smallest forward distance from r
    always_comb begin
        int best_d;
        int d;
        best_d = N_ROAD;
        d      = 0;
        next   = IDXW'((int'(r) + 1) % N_ROAD);
        for (int i = 0; i < N_ROAD; i++) begin
            d = (i - int'(r) + N_ROAD) % N_ROAD;
            if (demand[i] && (d != 0) && (d < best_d)) begin
                best_d = d;
                next   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/tl_cntr_nway.sv
// tl_cntr_nway: N-way round-robin traffic-light controller with optional
// protected left-turn phases, minimum green, fixed yellow and demand skipping.
// Optional feature macro: TL_MAX_GREEN_EN -- when defined, a green or left
// phase is cut at MAX_GREEN cycles if another road is waiting.
// All outputs are registered from the state registers (Moore).
module tl_cntr_nway
    import tl_pkg::*;
#(
    parameter int  N_ROAD     = 2,
    parameter int  GREEN_MIN  = 4,
    parameter int  YELLOW_CYC = 2,
    parameter int  MAX_GREEN  = 16,
    localparam int IDXW       = idx_w(N_ROAD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_ROAD-1:0]   t_thru,
    input  logic [N_ROAD-1:0]   t_left,
    output logic [2*N_ROAD-1:0] light,
    output logic [IDXW-1:0]     active_road,
    output logic                phase_chg
);

`ifdef TL_MAX_GREEN_EN
    localparam bit MAXG_EN = 1'b1;
`else
    localparam bit MAXG_EN = 1'b0;
`endif

    // The timer only needs to reach the largest threshold it is compared
    // against; the yellow count is included so a yellow longer than the
    // hold threshold can still terminate.
    localparam int T_HOLD = MAXG_EN ? (MAX_GREEN - 1) : (GREEN_MIN - 1);
    localparam int T_SAT  = (T_HOLD > YELLOW_CYC - 1) ? T_HOLD : (YELLOW_CYC - 1);
    localparam int TW     = cnt_w(T_SAT);

    localparam logic [TW-1:0] T_MAX  = TW'(T_SAT);
    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] T_MAXG = TW'(MAX_GREEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] road_nxt;
    logic [IDXW-1:0] rr_pick;
    logic [TW-1:0]   timer;

    logic            thru_r;
    logic            left_r;
    logic            other_dem;
    logic            yel_done;
    logic            preempt;

    // Lamp vector for a given phase on a given road; every other road is red
    function automatic logic [2*N_ROAD-1:0] lamp_vec(input state_t s,
                                                     input logic [IDXW-1:0] r);
        logic [2*N_ROAD-1:0] v;
        logic [1:0]          code;
        case (s)
            S_G:     code = L_GREEN;
            S_L:     code = L_LEFT;
            default: code = L_YELLOW;
        endcase
        v = {N_ROAD{L_RED}};
        for (int i = 0; i < N_ROAD; i++) begin
            if (i == int'(r)) begin
                v[2*i +: 2] = code;
            end
        end
        return v;
    endfunction

    // Sensors of the served road, and whether anyone else is waiting
    always_comb begin
        thru_r    = 1'b0;
        left_r    = 1'b0;
        other_dem = 1'b0;
        for (int i = 0; i < N_ROAD; i++) begin
            if (i == int'(active_road)) begin
                thru_r = t_thru[i];
                left_r = t_left[i];
            end else begin
                other_dem = other_dem | t_thru[i] | t_left[i];
            end
        end
    end

    assign yel_done = (timer == T_YEL);
    assign preempt  = MAXG_EN && (timer == T_MAXG) && other_dem;

    tl_rr_next #(
        .N_ROAD (N_ROAD),
        .IDXW   (IDXW)
    ) u_rr_next (
        .r      (active_road),
        .demand (t_thru | t_left),
        .next   (rr_pick)
    );

    // Next-state decode; the road pick is only consumed in the last yellow cycle
    always_comb begin
        state_nxt = state;
        road_nxt  = active_road;
        case (state)
            S_G: begin
                if (((timer >= T_GMIN) && !thru_r) || preempt) begin
                    state_nxt = S_GY;
                end
            end
            S_GY: begin
                if (yel_done) begin
                    if (left_r) begin
                        state_nxt = S_L;
                    end else begin
                        state_nxt = S_G;
                        road_nxt  = rr_pick;
                    end
                end
            end
            S_L: begin
                if (((timer >= T_GMIN) && !left_r) || preempt) begin
                    state_nxt = S_LY;
                end
            end
            S_LY: begin
                if (yel_done) begin
                    state_nxt = S_G;
                    road_nxt  = rr_pick;
                end
            end
            default: begin
                state_nxt = S_G;
            end
        endcase
    end

    // Phase timer: cleared on every state change, saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    // State, served road and registered lamp/pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_G;
            active_road <= '0;
            phase_chg   <= 1'b0;
            light       <= lamp_vec(S_G, '0);
        end else begin
            state       <= state_nxt;
            active_road <= road_nxt;
            phase_chg   <= (state_nxt == S_G) && (road_nxt != active_road);
            light       <= lamp_vec(state_nxt, road_nxt);
        end
    end

endmodule

// File: tb/tb_tl_cntr_nway.sv
// tb_tl_cntr_nway: scenario bench for tl_cntr_nway. A two-road instance
// carries most scenarios; a four-road instance covers demand skipping.
module tb_tl_cntr_nway;

    localparam logic [1:0] C_G = 2'b00;
    localparam logic [1:0] C_Y = 2'b01;
    localparam logic [1:0] C_L = 2'b10;

    typedef struct packed {
        logic [3:0] light;
        logic [0:0] road;
        logic       pc;
    } exp2_t;

    typedef struct packed {
        logic [7:0] light;
        logic [1:0] road;
        logic       pc;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst2;
    logic [1:0] thru2;
    logic [1:0] left2;
    logic [3:0] light2;
    logic [0:0] road2;
    logic       pc2;

    logic       rst4;
    logic [3:0] thru4;
    logic [3:0] left4;
    logic [7:0] light4;
    logic [1:0] road4;
    logic       pc4;

    exp2_t sb2[$];
    exp4_t sb4[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tl_cntr_nway #(
        .N_ROAD     (2),
        .GREEN_MIN  (4),
        .YELLOW_CYC (2),
        .MAX_GREEN  (16)
    ) dut2 (
        .clk         (clk),
        .reset       (rst2),
        .t_thru      (thru2),
        .t_left      (left2),
        .light       (light2),
        .active_road (road2),
        .phase_chg   (pc2)
    );

    tl_cntr_nway #(
        .N_ROAD     (4),
        .GREEN_MIN  (4),
        .YELLOW_CYC (2),
        .MAX_GREEN  (16)
    ) dut4 (
        .clk         (clk),
        .reset       (rst4),
        .t_thru      (thru4),
        .t_left      (left4),
        .light       (light4),
        .active_road (road4),
        .phase_chg   (pc4)
    );

    function automatic logic [3:0] lamp2(input int r, input logic [1:0] code);
        logic [3:0] v;
        v = 4'b1111;
        for (int i = 0; i < 2; i++) if (i == r) v[2*i +: 2] = code;
        return v;
    endfunction

    function automatic logic [7:0] lamp4(input int r, input logic [1:0] code);
        logic [7:0] v;
        v = 8'hFF;
        for (int i = 0; i < 4; i++) if (i == r) v[2*i +: 2] = code;
        return v;
    endfunction

    function automatic exp2_t mk2(input int r, input logic [1:0] code, input logic pc);
        exp2_t e;
        e.light = lamp2(r, code);
        e.road  = 1'(r);
        e.pc    = pc;
        return e;
    endfunction

    // Road1 reaches LEFT, then reset mid-arrow returns straight to road0 GREEN
    task automatic test_reset();
        exp2_t g;
        int r;
        logic [1:0] code;
        logic pc;
        rst2 = 1'b1; thru2 = 2'b00; left2 = 2'b10;
        for (int c = 0; c <= 17; c++) begin
            r = 0; pc = 1'b0; code = C_G;
            if (c >= 4 && c <= 5)       code = C_Y;
            else if (c >= 6 && c <= 9)  begin r = 1; pc = (c == 6); end
            else if (c >= 10 && c <= 11) begin r = 1; code = C_Y; end
            else if (c >= 12 && c <= 13) begin r = 1; code = C_L; end
            sb2.push_back(mk2(r, code, pc));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL reset c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2 = (c == 13);
        end
    endtask

    // No traffic: 4 green + 2 yellow per road, endless rotation
    task automatic test_idle_rotation();
        exp2_t g;
        int p;
        rst2 = 1'b1; thru2 = 2'b00; left2 = 2'b00;
        for (int c = 0; c < 24; c++) begin
            p = c % 6;
            sb2.push_back(mk2((c / 6) % 2, (p < 4) ? C_G : C_Y, (p == 0) && (c > 0)));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL idle c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2 = 1'b0;
        end
    endtask

    // Extended green, then a left arrow held at its minimum before yellow
    task automatic test_thru_left();
        exp2_t g;
        int r;
        logic [1:0] code;
        logic pc;
        rst2 = 1'b1; thru2 = 2'b00; left2 = 2'b00;
        for (int c = 0; c <= 25; c++) begin
            r = 0; pc = 1'b0; code = C_G;
            if (c >= 10 && c <= 11)      code = C_Y;
            else if (c >= 12 && c <= 15) code = C_L;
            else if (c >= 16 && c <= 17) code = C_Y;
            else if (c >= 18 && c <= 21) begin r = 1; pc = (c == 18); end
            else if (c >= 22 && c <= 23) begin r = 1; code = C_Y; end
            else if (c >= 24)            pc = (c == 24);
            sb2.push_back(mk2(r, code, pc));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL thru_left c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2     = 1'b0;
            thru2[0] = (c <= 8);
            left2[0] = (c <= 13);
        end
    endtask

    // Left request seen only in the first yellow cycle is ignored
    task automatic test_left_pulse();
        exp2_t g;
        int p;
        rst2 = 1'b1; thru2 = 2'b00; left2 = 2'b00;
        for (int c = 0; c < 12; c++) begin
            p = c % 6;
            sb2.push_back(mk2((c / 6) % 2, (p < 4) ? C_G : C_Y, (p == 0) && (c > 0)));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL left_pulse c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2     = 1'b0;
            left2[0] = (c == 4);
        end
    endtask

    // Left request present in the last yellow cycle opens the arrow
    task automatic test_left_last_yellow();
        exp2_t g;
        int r;
        logic [1:0] code;
        logic pc;
        rst2 = 1'b1; thru2 = 2'b00; left2 = 2'b00;
        for (int c = 0; c <= 13; c++) begin
            r = 0; pc = 1'b0; code = C_G;
            if (c >= 4 && c <= 5)        code = C_Y;
            else if (c >= 6 && c <= 9)   code = C_L;
            else if (c >= 10 && c <= 11) code = C_Y;
            else if (c >= 12)            begin r = 1; pc = (c == 12); end
            sb2.push_back(mk2(r, code, pc));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL left_last_y c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2     = 1'b0;
            left2[0] = (c >= 5 && c <= 7);
        end
    endtask

    // Stuck through sensor: held green (or cut at MAX_GREEN when enabled and
    // road1 waits); then a lone stuck road must release immediately on drop
    task automatic test_max_green();
        exp2_t g;
        int r;
        logic [1:0] code;
        logic pc;
        rst2 = 1'b1; thru2 = 2'b11; left2 = 2'b00;
        for (int c = 0; c < 30; c++) begin
            r = 0; pc = 1'b0; code = C_G;
`ifdef TL_MAX_GREEN_EN
            if (c >= 16 && c <= 17) code = C_Y;
            else if (c >= 18)       begin r = 1; pc = (c == 18); end
`endif
            sb2.push_back(mk2(r, code, pc));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL max_green c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2 = 1'b0;
        end
        rst2 = 1'b1; thru2 = 2'b01;
        for (int c = 0; c <= 33; c++) begin
            r = 0; pc = 1'b0; code = C_G;
            if (c >= 31 && c <= 32) code = C_Y;
            else if (c == 33)       begin r = 1; pc = 1'b1; end
            sb2.push_back(mk2(r, code, pc));
            @(posedge clk); #1;
            g = sb2.pop_front();
            n_checks++;
            if ({light2, road2, pc2} !== g) begin
                $display("FAIL hold_alone c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light2, road2, pc2, g.light, g.road, g.pc);
            end else n_pass++;
            rst2     = 1'b0;
            thru2[0] = (c < 30);
        end
    endtask

    // Four roads: 0 -> 3 skipping idle 1,2; then 3 -> 1 wrapping past idle 0
    task automatic test_skip_n4();
        exp4_t e;
        exp4_t g;
        int r;
        logic [1:0] code;
        logic pc;
        rst4 = 1'b1; thru4 = 4'b1000; left4 = 4'b0000;
        for (int c = 0; c <= 13; c++) begin
            r = 0; pc = 1'b0; code = C_G;
            if (c >= 4 && c <= 5)        code = C_Y;
            else if (c >= 6 && c <= 9)   begin r = 3; pc = (c == 6); end
            else if (c >= 10 && c <= 11) begin r = 3; code = C_Y; end
            else if (c >= 12)            begin r = 1; pc = (c == 12); end
            e.light = lamp4(r, code);
            e.road  = 2'(r);
            e.pc    = pc;
            sb4.push_back(e);
            @(posedge clk); #1;
            g = sb4.pop_front();
            n_checks++;
            if ({light4, road4, pc4} !== g) begin
                $display("FAIL skip_n4 c=%0d: light=%b road=%0d pc=%b, want light=%b road=%0d pc=%b",
                         c, light4, road4, pc4, g.light, g.road, g.pc);
            end else n_pass++;
            rst4     = 1'b0;
            thru4[3] = (c <= 7);
            left4[1] = (c >= 8);
        end
    endtask

    initial begin
        rst2 = 1'b1; thru2 = '0; left2 = '0;
        rst4 = 1'b1; thru4 = '0; left4 = '0;
        @(posedge clk); #1;
        test_reset();
        test_idle_rotation();
        test_thru_left();
        test_left_pulse();
        test_left_last_yellow();
        test_max_green();
        test_skip_n4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
